// File: rtl/vga_board_renderer_if.sv
// Renderer-side signal bundle: pixel enable, board-memory lookup and VGA outputs.
// Every field is sampled and updated only on clk edges with pix_en=1; cell_rgb answers the address one tick later.
interface vga_board_renderer_if;
    logic       pix_en;
    logic [2:0] cell_rgb;
    logic [3:0] cell_col;
    logic [4:0] cell_row;
    logic       R;
    logic       G;
    logic       B;
    logic       hs;
    logic       vs;
    logic       frame_start;

    modport master (
        input  pix_en, cell_rgb,
        output cell_col, cell_row, R, G, B, hs, vs, frame_start
    );

    modport slave (
        output pix_en, cell_rgb,
        input  cell_col, cell_row, R, G, B, hs, vs, frame_start
    );
endinterface

// File: rtl/vga_board_renderer.sv
// VGA timing plus Tetris playfield renderer: counters -> address/flags -> colour, 2-tick latency.
// All state advances only on pix_en; sync and colour leave through the same pipeline depth.
module vga_board_renderer #(
    parameter int H_ACTIVE   = 640,
    parameter int H_FP       = 16,
    parameter int H_SYNC     = 96,
    parameter int H_BP       = 48,
    parameter int V_ACTIVE   = 480,
    parameter int V_FP       = 10,
    parameter int V_SYNC     = 2,
    parameter int V_BP       = 33,
    parameter int BOARD_X0   = 240,
    parameter int BOARD_Y0   = 80,
    parameter int CELL_SHIFT = 4,
    parameter int BOARD_COLS = 10,
    parameter int BOARD_ROWS = 20,
    parameter int BORDER     = 4
) (
    input  logic                    clk,
    input  logic                    reset,
    vga_board_renderer_if.master    bus
);
    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int HW      = $clog2(H_TOTAL);
    localparam int VW      = $clog2(V_TOTAL);
    localparam int BOARD_W = BOARD_COLS << CELL_SHIFT;
    localparam int BOARD_H = BOARD_ROWS << CELL_SHIFT;

    localparam logic [HW-1:0] H_MAX  = HW'(H_TOTAL - 1);
    localparam logic [HW-1:0] H_ACT  = HW'(H_ACTIVE);
    localparam logic [HW-1:0] HS_BEG = HW'(H_ACTIVE + H_FP);
    localparam logic [HW-1:0] HS_END = HW'(H_ACTIVE + H_FP + H_SYNC - 1);
    localparam logic [HW-1:0] BX0    = HW'(BOARD_X0);
    localparam logic [HW-1:0] BX1    = HW'(BOARD_X0 + BOARD_W - 1);
    localparam logic [HW-1:0] OX0    = HW'(BOARD_X0 - BORDER);
    localparam logic [HW-1:0] OX1    = HW'(BOARD_X0 + BOARD_W + BORDER - 1);

    localparam logic [VW-1:0] V_MAX  = VW'(V_TOTAL - 1);
    localparam logic [VW-1:0] V_ACT  = VW'(V_ACTIVE);
    localparam logic [VW-1:0] VS_BEG = VW'(V_ACTIVE + V_FP);
    localparam logic [VW-1:0] VS_END = VW'(V_ACTIVE + V_FP + V_SYNC - 1);
    localparam logic [VW-1:0] BY0    = VW'(BOARD_Y0);
    localparam logic [VW-1:0] BY1    = VW'(BOARD_Y0 + BOARD_H - 1);
    localparam logic [VW-1:0] OY0    = VW'(BOARD_Y0 - BORDER);
    localparam logic [VW-1:0] OY1    = VW'(BOARD_Y0 + BOARD_H + BORDER - 1);

    logic [HW-1:0] h_q, h_d;
    logic [VW-1:0] v_q, v_d;
    logic          first_q, first_d;
    logic          frame_start_q, frame_start_d;
    logic          act_1_q, act_1_d;
    logic          hs_1_q, hs_1_d;
    logic          vs_1_q, vs_1_d;
    logic          board_1_q, board_1_d;
    logic          border_1_q, border_1_d;
    logic [3:0]    cell_col_q, cell_col_d;
    logic [4:0]    cell_row_q, cell_row_d;
    logic [2:0]    rgb_q, rgb_d;
    logic          hs_q, hs_d;
    logic          vs_q, vs_d;

    logic act_0, hs_0, vs_0, board_0, outer_0, border_0;

    always_comb begin
        act_0    = (h_q < H_ACT) && (v_q < V_ACT);
        hs_0     = !((h_q >= HS_BEG) && (h_q <= HS_END));
        vs_0     = !((v_q >= VS_BEG) && (v_q <= VS_END));
        board_0  = (h_q >= BX0) && (h_q <= BX1) && (v_q >= BY0) && (v_q <= BY1);
        outer_0  = (h_q >= OX0) && (h_q <= OX1) && (v_q >= OY0) && (v_q <= OY1);
        border_0 = outer_0 && !board_0;
    end

    always_comb begin
        h_d           = h_q;
        v_d           = v_q;
        first_d       = first_q;
        frame_start_d = 1'b0;
        act_1_d       = act_1_q;
        hs_1_d        = hs_1_q;
        vs_1_d        = vs_1_q;
        board_1_d     = board_1_q;
        border_1_d    = border_1_q;
        cell_col_d    = cell_col_q;
        cell_row_d    = cell_row_q;
        rgb_d         = rgb_q;
        hs_d          = hs_q;
        vs_d          = vs_q;
        if (bus.pix_en) begin
            h_d = (h_q == H_MAX) ? '0 : h_q + 1'b1;
            if (h_q == H_MAX) begin
                v_d = (v_q == V_MAX) ? '0 : v_q + 1'b1;
            end
            // The first tick after reset also counts as a frame start.
            frame_start_d = first_q || ((h_q == H_MAX) && (v_q == V_MAX));
            first_d       = 1'b0;

            act_1_d    = act_0;
            hs_1_d     = hs_0;
            vs_1_d     = vs_0;
            board_1_d  = board_0;
            border_1_d = border_0;
            cell_col_d = board_0 ? 4'((h_q - BX0) >> CELL_SHIFT) : 4'd0;
            cell_row_d = board_0 ? 5'((v_q - BY0) >> CELL_SHIFT) : 5'd0;

            if (!act_1_q)        rgb_d = 3'b000;
            else if (board_1_q)  rgb_d = bus.cell_rgb;
            else if (border_1_q) rgb_d = 3'b111;
            else                 rgb_d = 3'b000;
            hs_d = hs_1_q;
            vs_d = vs_1_q;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            h_q           <= '0;
            v_q           <= '0;
            first_q       <= 1'b1;
            frame_start_q <= 1'b0;
            act_1_q       <= 1'b0;
            // Sync stages reset to the inactive level so no stray pulse leaves the pipe.
            hs_1_q        <= 1'b1;
            vs_1_q        <= 1'b1;
            board_1_q     <= 1'b0;
            border_1_q    <= 1'b0;
            cell_col_q    <= '0;
            cell_row_q    <= '0;
            rgb_q         <= '0;
            hs_q          <= 1'b1;
            vs_q          <= 1'b1;
        end else begin
            h_q           <= h_d;
            v_q           <= v_d;
            first_q       <= first_d;
            frame_start_q <= frame_start_d;
            act_1_q       <= act_1_d;
            hs_1_q        <= hs_1_d;
            vs_1_q        <= vs_1_d;
            board_1_q     <= board_1_d;
            border_1_q    <= border_1_d;
            cell_col_q    <= cell_col_d;
            cell_row_q    <= cell_row_d;
            rgb_q         <= rgb_d;
            hs_q          <= hs_d;
            vs_q          <= vs_d;
        end
    end

    assign bus.cell_col    = cell_col_q;
    assign bus.cell_row    = cell_row_q;
    assign bus.R           = rgb_q[2];
    assign bus.G           = rgb_q[1];
    assign bus.B           = rgb_q[0];
    assign bus.hs          = hs_q;
    assign bus.vs          = vs_q;
    assign bus.frame_start = frame_start_q;
endmodule

// File: tb/tb_vga_board_renderer.sv
// Directed bench for vga_board_renderer on a scaled-down raster (88x65 ticks, 2x2-pixel cells).
// Bench counts pix_en ticks itself; pixel p is expected on the outputs after tick p+2.
module tb_vga_board_renderer;
    localparam int H_ACTIVE = 64, H_FP = 6, H_SYNC = 10, H_BP = 8;
    localparam int V_ACTIVE = 56, V_FP = 3, V_SYNC = 2, V_BP = 4;
    localparam int H_TOTAL  = 88;
    localparam int FRAME    = 88 * 65;

    logic clk = 1'b0;
    logic reset;
    logic hold = 1'b0;
    logic force_rgb;
    logic mon_en;
    logic [2:0] mem_q;
    logic hs_p = 1'b1;
    logic vs_p = 1'b1;
    int tick = 0;
    int n_checks = 0;
    int n_fail = 0;
    int hs_fall_q[$], hs_rise_q[$], vs_fall_q[$], vs_rise_q[$], fs_q[$];

    always #5 clk = ~clk;

    vga_board_renderer_if bus ();

    vga_board_renderer #(
        .H_ACTIVE(H_ACTIVE), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
        .V_ACTIVE(V_ACTIVE), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP),
        .BOARD_X0(16), .BOARD_Y0(8), .CELL_SHIFT(1),
        .BOARD_COLS(10), .BOARD_ROWS(20), .BORDER(2)
    ) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus)
    );

    // Board memory model: {col[0], row[0], 1}, one clk behind the address.
    always @(posedge clk) mem_q <= {bus.cell_col[0], bus.cell_row[0], 1'b1};
    assign bus.cell_rgb = force_rgb ? 3'b111 : mem_q;

    initial begin
        bus.pix_en = 1'b0;
        forever begin
            @(negedge clk);
            if (hold) bus.pix_en = 1'b0;
            else      bus.pix_en = ~bus.pix_en;
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            if (reset)           tick = 0;
            else if (bus.pix_en) tick++;
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (mon_en) begin
                if (hs_p && !bus.hs) hs_fall_q.push_back(tick);
                if (!hs_p && bus.hs) hs_rise_q.push_back(tick);
                if (vs_p && !bus.vs) vs_fall_q.push_back(tick);
                if (!vs_p && bus.vs) vs_rise_q.push_back(tick);
                if (bus.frame_start) fs_q.push_back(tick);
            end
            hs_p = bus.hs;
            vs_p = bus.vs;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic wait_tick(input int t);
        int guard = 0;
        while (tick < t && guard < 50000) begin
            @(negedge clk);
            guard++;
        end
        if (tick != t) check("wait_tick", tick, t);
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, ".rgb"}, {bus.R, bus.G, bus.B}, 3'b000);
        check({tag, ".hs"}, bus.hs, 1'b1);
        check({tag, ".vs"}, bus.vs, 1'b1);
        check({tag, ".fs"}, bus.frame_start, 1'b0);
        check({tag, ".col"}, bus.cell_col, 4'd0);
        check({tag, ".row"}, bus.cell_row, 5'd0);
    endtask

    task automatic check_pixel(input string tag, input int x, input int y, input logic [2:0] rgb,
                               input logic [3:0] col, input logic [4:0] row, input int base,
                               input logic frc);
        int p;
        p = base + y * H_TOTAL + x;
        wait_tick(p + 1);
        check({tag, ".col"}, bus.cell_col, col);
        check({tag, ".row"}, bus.cell_row, row);
        force_rgb = frc;
        wait_tick(p + 2);
        check({tag, ".rgb"}, {bus.R, bus.G, bus.B}, rgb);
        force_rgb = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        force_rgb = 1'b0;
        mon_en = 1'b0;
        repeat (5) @(negedge clk);
        check_reset_vals("reset");
        reset = 1'b0;
        mon_en = 1'b1;

        wait_tick(1);
        check("fs_first", bus.frame_start, 1'b1);
        @(negedge clk);
        check("fs_first_end", bus.frame_start, 1'b0);

        // Board x 16..35, y 8..47; border ring x 14..37, y 6..49.
        check_pixel("blank_left_top", 5, 7, 3'b000, 4'd0, 5'd0, 0, 1'b0);
        check_pixel("border_top",    25, 7, 3'b111, 4'd0, 5'd0, 0, 1'b0);
        check_pixel("border_left8",  15, 8, 3'b111, 4'd0, 5'd0, 0, 1'b0);
        check_pixel("cell_0_0",      16, 8, 3'b001, 4'd0, 5'd0, 0, 1'b0);
        check_pixel("cell_0_0_in",   17, 9, 3'b001, 4'd0, 5'd0, 0, 1'b0);
        check_pixel("cell_0_1",      16, 10, 3'b011, 4'd0, 5'd1, 0, 1'b0);
        check_pixel("cell_1_1",      18, 10, 3'b111, 4'd1, 5'd1, 0, 1'b0);
        check_pixel("cell_3_2",      22, 12, 3'b101, 4'd3, 5'd2, 0, 1'b0);

        // Freeze with outputs on (29,20) and address on (30,20).
        wait_tick(20 * H_TOTAL + 29 + 2);
        hold = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("hold.rgb", {bus.R, bus.G, bus.B}, 3'b001);
            check("hold.col", bus.cell_col, 4'd7);
            check("hold.row", bus.cell_row, 5'd6);
        end
        hold = 1'b0;
        wait_tick(20 * H_TOTAL + 29 + 3);
        check("resume.rgb", {bus.R, bus.G, bus.B}, 3'b101);
        wait_tick(20 * H_TOTAL + 29 + 4);
        check("resume.col", bus.cell_col, 4'd8);

        check_pixel("outside_left",   6, 30, 3'b000, 4'd0, 5'd0, 0, 1'b0);
        check_pixel("outside_edge",  13, 30, 3'b000, 4'd0, 5'd0, 0, 1'b0);
        check_pixel("border_left",   14, 30, 3'b111, 4'd0, 5'd0, 0, 1'b0);
        check_pixel("cell_9_11",     35, 30, 3'b111, 4'd9, 5'd11, 0, 1'b0);
        check_pixel("border_right",  37, 30, 3'b111, 4'd0, 5'd0, 0, 1'b0);
        check_pixel("outside_right", 38, 30, 3'b000, 4'd0, 5'd0, 0, 1'b0);
        check_pixel("cell_9_19",     35, 47, 3'b111, 4'd9, 5'd19, 0, 1'b0);
        check_pixel("border_bottom", 25, 48, 3'b111, 4'd0, 5'd0, 0, 1'b0);
        check_pixel("below_border",  25, 50, 3'b000, 4'd0, 5'd0, 0, 1'b0);
        check_pixel("active_empty",  50, 52, 3'b000, 4'd0, 5'd0, 0, 1'b0);
        check_pixel("hblank_forced", 70, 53, 3'b000, 4'd0, 5'd0, 0, 1'b1);

        wait_tick(FRAME - 1);
        check("fs_before_wrap", bus.frame_start, 1'b0);
        wait_tick(FRAME);
        check("fs_wrap", bus.frame_start, 1'b1);
        check_pixel("f2_cell_0_0", 16, 8, 3'b001, 4'd0, 5'd0, FRAME, 1'b0);

        wait_tick(2 * FRAME + 5);
        // hs falls at h=70 of each line, 2 ticks late: 72 + 88k up to tick 11445 -> 130 lines.
        check("hs_fall_count", hs_fall_q.size(), 130);
        if (hs_fall_q.size() >= 2 && hs_rise_q.size() >= 1) begin
            check("hs_fall_first", hs_fall_q[0], 72);
            check("hs_low_width", hs_rise_q[0] - hs_fall_q[0], H_SYNC);
            check("hs_period", hs_fall_q[1] - hs_fall_q[0], H_TOTAL);
        end
        // vs falls at line 59: 59*88 + 2 = 5194, low for 2 lines.
        check("vs_fall_count", vs_fall_q.size(), 2);
        if (vs_fall_q.size() >= 2 && vs_rise_q.size() >= 1) begin
            check("vs_fall_first", vs_fall_q[0], 5194);
            check("vs_low_width", vs_rise_q[0] - vs_fall_q[0], 2 * H_TOTAL);
            check("vs_period", vs_fall_q[1] - vs_fall_q[0], FRAME);
        end
        check("fs_count", fs_q.size(), 3);
        if (fs_q.size() >= 3) begin
            check("fs_tick_1", fs_q[0], 1);
            check("fs_tick_2", fs_q[1], FRAME);
            check("fs_tick_3", fs_q[2], 2 * FRAME);
        end
        mon_en = 1'b0;

        // Mid-frame reset with outputs on (30,28) and address on (31,28).
        wait_tick(2 * FRAME + 28 * H_TOTAL + 32);
        check("pre_reset.rgb", {bus.R, bus.G, bus.B}, 3'b101);
        check("pre_reset.col", bus.cell_col, 4'd7);
        check("pre_reset.row", bus.cell_row, 5'd10);
        reset = 1'b1;
        @(negedge clk);
        check_reset_vals("mid_reset");
        @(negedge clk);
        reset = 1'b0;
        wait_tick(1);
        check("fs_after_reset", bus.frame_start, 1'b1);
        check_pixel("post_reset_cell", 16, 8, 3'b001, 4'd0, 5'd0, 0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
